// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit and receive paths.
package spart_pkg;
    typedef enum logic {IDLE, TX} state_t;

    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
endpackage

// File: rtl/spart_baud_gen.sv
// Loadable 16-bit baud down-counter; tick marks the last cycle of each bit period.
module spart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] div,
    output logic        tick
);
    logic [15:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (load || tick)
            cnt_d = div;
        else if (en)
            cnt_d = cnt_q - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding buffer feeding an 8N1 shift register.
module spart_tx
    import spart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divisor_buffer,
    input  logic [7:0]  tx_data,
    input  logic        tx_load,
    output logic        tbr,
    output logic        tx_busy,
    output logic        txd
);
    state_t                  state_q;
    logic [7:0]              hold_q;
    logic                    hold_full_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [3:0]              bitcnt_q;
    logic [15:0]             div_q;

    logic        tick;
    logic        frame_end;
    logic        start_frame;
    logic [15:0] baud_div;

    assign frame_end   = (state_q == TX) && tick && (bitcnt_q == 4'd1);
    assign start_frame = hold_full_q && ((state_q == IDLE) || frame_end);
    // A new frame takes the divisor live, since div_q is only updated on the same edge.
    assign baud_div    = start_frame ? divisor_buffer : div_q;

    spart_baud_gen u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (start_frame),
        .en   (state_q == TX),
        .div  (baud_div),
        .tick (tick)
    );

    // The shifter idles as all ones, so its LSB is the line level at all times.
    assign txd     = shift_q[0];
    assign tbr     = ~hold_full_q;
    assign tx_busy = (state_q == TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= '1;
            bitcnt_q    <= 4'd0;
            div_q       <= 16'd0;
        end else begin
            if (tx_load && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end else if (start_frame) begin
                hold_full_q <= 1'b0;
            end

            if (start_frame) begin
                state_q  <= TX;
                shift_q  <= {STOP_BIT, hold_q, START_BIT};
                bitcnt_q <= 4'(FRAME_BITS);
                div_q    <= divisor_buffer;
            end else begin
                case (state_q)
                    IDLE: shift_q <= '1;
                    TX: begin
                        if (tick) begin
                            shift_q  <= {1'b1, shift_q[FRAME_BITS-1:1]};
                            bitcnt_q <= bitcnt_q - 4'd1;
                            if (frame_end)
                                state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spart_tx.md
Name: spart_tx

Overview:
Serial transmitter for the SPART, the transmit-side counterpart of the SPART receive path. It accepts a byte from the bus/control logic into a one-byte holding buffer. It serialises the byte on txd as an 8N1 frame: start bit 0, data bits d0..d7 LSB first, stop bit 1. Bit timing comes from the same 16-bit divisor_buffer the receiver uses. Control logic polls tbr (transmit buffer ready) to decide when it may write the next byte.

Parameters:
FRAME_BITS, 10, bits per frame (1 start + 8 data + 1 stop); fixed and not intended to be overridden.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
divisor_buffer  input  16  baud divisor; each bit lasts divisor_buffer+1 clk cycles; sampled at frame start.
tx_data  input  8  byte to transmit; valid when tx_load=1.
tx_load  input  1  write strobe; one-cycle pulse from control logic.
tbr  output  1  transmit buffer ready; 1 = holding buffer empty, write accepted.
tx_busy  output  1  1 while a frame is on the line (START through STOP).
txd  output  1  serial line, registered; idle high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: txd=1, tbr=1, tx_busy=0.
  - Internals: state=IDLE, holding buffer empty, baud counter and bit counter cleared.
  - Reset mid-frame aborts the frame; txd returns high on the same edge and no partial byte is resumed.
- Holding buffer:
  - tx_load=1 with tbr=1 captures tx_data; tbr=0 from the next cycle.
  - tx_load=1 with tbr=0 is ignored; the holding contents are unchanged and no error is flagged.
- State machine (from shared state_t): IDLE, TX.
  - IDLE -> TX:
    - Condition: at any edge where the holding buffer is full.
    - Shift register loads {1'b1, holding, 1'b0}; the stop bit is at the MSB and the start bit at the LSB.
    - divisor_buffer is latched into div_q; the bit counter is set to FRAME_BITS.
    - The baud counter loads div_q; the holding buffer empties, so tbr=1 from the next cycle.
  - TX:
    - txd = shift_reg[0] (registered), so the start bit appears one cycle after the holding buffer fills.
    - The baud counter counts down each cycle. At 0 it reloads div_q, the shift register shifts right filling 1, and the bit counter decrements.
  - End of stop bit (bit counter reaches 0 on a baud tick):
    - If the holding buffer is full, reload as in IDLE->TX on the same edge. The next start bit follows with no idle gap.
    - Otherwise go to IDLE; txd=1.
- Latency:
  - tx_load sampled at edge N (shifter idle) -> start bit on txd after edge N+1.
  - Full frame = 10*(div+1) cycles.
- tbr behaviour:
  - tbr reasserts one cycle after the transfer into the shifter.
  - This allows the next byte to be buffered during the current frame (double buffering).
- divisor_buffer changes mid-frame have no effect until the next frame start.
- divisor_buffer=0 gives 1 cycle per bit; this is legal.
- tx_busy=1 exactly while state=TX.
- Counters are 16-bit unsigned with no wrap: the baud counter reloads at 0 and never decrements below 0.

Decomposition:
- Package spart_pkg holds:
  - typedef enum state_t {IDLE, TX}.
  - localparam FRAME_BITS=10.
  - localparams START_BIT=1'b0 and STOP_BIT=1'b1.
- One sub-module: spart_baud_gen.
  - Function: loadable 16-bit down-counter with inputs load, div, en and output tick.
  - tick asserts in the cycle the count equals 0; the counter reloads from div on tick.
  - It is reusable by the receive path.

Test Plan:
- Single byte: reset, divisor=3, tx_load with 0xA5.
  - txd sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles.
  - tx_busy high 40 cycles; then txd=1 and tbr=1.
- Back-to-back: divisor=3.
  - Load 0x00, then load 0xFF as soon as tbr=1.
  - Expect 0x00 frame immediately followed by a 0xFF frame with no idle cycle: txd low 36 cycles, high 4, low 4, high 36.
- Overrun ignored: divisor=3.
  - Load 0x11, then 0x22 (accepted into holding), then 0x33 while tbr=0.
  - Only 0x11 and 0x22 are transmitted; 0x33 never appears.
- Reset mid-frame: divisor=7.
  - Load 0x5A and assert rst at cycle 30.
  - Next edge: txd=1, tbr=1, tx_busy=0; no further transitions without a new tx_load.
- Divisor change: start a frame with divisor=3, then change to 9 mid-frame.
  - Current frame keeps 4 cycles/bit; the next frame uses 10 cycles/bit.
  - divisor=0 frame lasts 10 cycles.
- Loopback: txd drives the SPART receive path, same divisor=3, bytes 0x00, 0x55, 0xAA, 0xFF, 0x81.
  - Receiver flags data available for each byte with the matching payload and stop bit=1.
